// File: rtl/fatori_err_collector.sv
// Fatori error collector: saturating per-source event counters, OK/DEGRADED/ALARM escalation
// and a registered read port. Define FATORI_ERR_TIMESTAMP_EN to add the ALARM-entry timestamp.
module fatori_err_collector #(
  parameter int unsigned NSRC       = 4,
  parameter int unsigned CW         = 16,
  parameter int unsigned ESC_THRESH = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NSRC-1:0] min_err_i,
  input  logic [NSRC-1:0] maj_err_i,
  input  logic [NSRC-1:0] scrub_i,
  input  logic            clr_i,
  input  logic            rd_req_i,
  input  logic [1:0]      rd_kind_i,
  input  logic [3:0]      rd_src_i,
  output logic            rd_valid_o,
  output logic [31:0]     rd_data_o,
  output logic            degraded_o,
  output logic            alarm_o,
  output logic            irq_o
);

  localparam int unsigned   DW       = 32;
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] ESC_LAST = CW'(ESC_THRESH - 1);

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_DEGRADED = 2'd1,
    ST_ALARM    = 2'd2
  } state_t;

  state_t        state;
  state_t        eff_state;
  logic [CW-1:0] esc_cnt;
  logic [CW-1:0] eff_esc;
  logic [CW-1:0] min_cnt [NSRC];
  logic [CW-1:0] maj_cnt [NSRC];
  logic [CW-1:0] scr_cnt [NSRC];
  logic          any_min;
  logic          any_maj;
  logic          alarm_entry;
  logic [DW-1:0] ts_val;
  logic [DW-1:0] rd_mux;

  // A clear in the same cycle as events is applied first, so the events land on the cleared state.
  assign any_min   = |min_err_i;
  assign any_maj   = |maj_err_i;
  assign eff_state = clr_i ? ST_OK : state;
  assign eff_esc   = clr_i ? '0 : esc_cnt;

  assign alarm_entry = (eff_state != ST_ALARM) &&
                       (any_maj || ((eff_state == ST_DEGRADED) && any_min && (eff_esc == ESC_LAST)));

  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt, input logic flag,
                                             input logic clr);
    logic [CW-1:0] base;
    base = clr ? '0 : cnt;
    if (flag && (base != CNT_MAX)) begin
      return base + CW'(1);
    end
    return base;
  endfunction

  // Event counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        min_cnt[i] <= '0;
        maj_cnt[i] <= '0;
        scr_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        min_cnt[i] <= cnt_next(min_cnt[i], min_err_i[i], clr_i);
        maj_cnt[i] <= cnt_next(maj_cnt[i], maj_err_i[i], clr_i);
        scr_cnt[i] <= cnt_next(scr_cnt[i], scrub_i[i], clr_i);
      end
    end
  end

  // Escalation FSM with registered status outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_OK;
      esc_cnt    <= '0;
      degraded_o <= 1'b0;
      alarm_o    <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      irq_o <= 1'b0;
      if (alarm_entry) begin
        state      <= ST_ALARM;
        esc_cnt    <= eff_esc;
        degraded_o <= 1'b0;
        alarm_o    <= 1'b1;
        irq_o      <= 1'b1;
      end else begin
        case (eff_state)
          ST_OK: begin
            esc_cnt    <= '0;
            alarm_o    <= 1'b0;
            state      <= any_min ? ST_DEGRADED : ST_OK;
            degraded_o <= any_min;
          end
          ST_DEGRADED: begin
            state      <= ST_DEGRADED;
            degraded_o <= 1'b1;
            alarm_o    <= 1'b0;
            esc_cnt    <= any_min ? eff_esc + CW'(1) : eff_esc;
          end
          default: begin
            state      <= ST_ALARM;
            degraded_o <= 1'b0;
            alarm_o    <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef FATORI_ERR_TIMESTAMP_EN
  logic [31:0] cyc_cnt;
  logic [31:0] ts_lat;

  // Free-running cycle count; the latch captures the cycle in which ALARM entry is decided.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_cnt <= '0;
      ts_lat  <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (alarm_entry) begin
        ts_lat <= cyc_cnt;
      end else if (clr_i) begin
        ts_lat <= '0;
      end
    end
  end

  assign ts_val = ts_lat;
`else
  assign ts_val = '0;
`endif

  // Read mux over pre-update register values
  always_comb begin
    rd_mux = '0;
    if (rd_kind_i == 2'd3) begin
      if (rd_src_i == 4'd0) begin
        rd_mux = {30'b0, state};
      end else if (rd_src_i == 4'd1) begin
        rd_mux = ts_val;
      end
    end else begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (rd_src_i == 4'(i)) begin
          case (rd_kind_i)
            2'd0:    rd_mux = DW'(min_cnt[i]);
            2'd1:    rd_mux = DW'(maj_cnt[i]);
            default: rd_mux = DW'(scr_cnt[i]);
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= rd_req_i;
      rd_data_o  <= rd_req_i ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_fatori_err_collector.sv
// Self-checking bench for fatori_err_collector: directed scenarios plus randomized traffic
// compared every cycle against a count-based reference model.
module tb_fatori_err_collector;

  localparam int unsigned NSRC = 4;
  localparam int unsigned ESC  = 8;
  localparam int          MAXD = 65535;
  localparam int          MAXS = 15;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [NSRC-1:0] min_err_i, maj_err_i, scrub_i;
  logic            clr_i, rd_req_i;
  logic [1:0]      rd_kind_i;
  logic [3:0]      rd_src_i;

  logic        rd_valid, degraded, alarm, irq;
  logic [31:0] rd_data;
  logic        s_rd_valid, s_degraded, s_alarm, s_irq;
  logic [31:0] s_rd_data;

  int checks   = 0;
  int failures = 0;

  int          m_min [NSRC];
  int          m_maj [NSRC];
  int          m_scr [NSRC];
  int          m_state;
  int          m_esc;
  bit          m_irq;
  logic [31:0] m_cyc;
  logic [31:0] m_ts;

  always #5 clk_i = ~clk_i;

  fatori_err_collector #(.NSRC(NSRC), .CW(16), .ESC_THRESH(ESC)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .min_err_i(min_err_i), .maj_err_i(maj_err_i),
    .scrub_i(scrub_i), .clr_i(clr_i), .rd_req_i(rd_req_i), .rd_kind_i(rd_kind_i),
    .rd_src_i(rd_src_i), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .degraded_o(degraded), .alarm_o(alarm), .irq_o(irq)
  );

  fatori_err_collector #(.NSRC(NSRC), .CW(4), .ESC_THRESH(ESC)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .min_err_i(min_err_i), .maj_err_i(maj_err_i),
    .scrub_i(scrub_i), .clr_i(clr_i), .rd_req_i(rd_req_i), .rd_kind_i(rd_kind_i),
    .rd_src_i(rd_src_i), .rd_valid_o(s_rd_valid), .rd_data_o(s_rd_data),
    .degraded_o(s_degraded), .alarm_o(s_alarm), .irq_o(s_irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NSRC; i++) begin
      m_min[i] = 0;
      m_maj[i] = 0;
      m_scr[i] = 0;
    end
    m_state = 0;
    m_esc   = 0;
    m_irq   = 1'b0;
    m_cyc   = '0;
    m_ts    = '0;
  endtask

  function automatic logic [31:0] exp_read(input int kind, input int src, input int maxv);
    int v;
    v = 0;
    if (kind == 3) begin
      if (src == 0) v = m_state;
`ifdef FATORI_ERR_TIMESTAMP_EN
      else if (src == 1) return m_ts;
`endif
    end else if (src < NSRC) begin
      v = (kind == 0) ? m_min[src] : (kind == 1) ? m_maj[src] : m_scr[src];
      if (v > maxv) v = maxv;
    end
    return 32'(v);
  endfunction

  // Model state: 0 OK, 1 DEGRADED, 2 ALARM; counts are unbounded and clipped on read.
  task automatic model_update(input logic [3:0] mn, mj, sc, input logic cl);
    m_irq = 1'b0;
    if (cl) begin
      for (int i = 0; i < NSRC; i++) begin
        m_min[i] = 0;
        m_maj[i] = 0;
        m_scr[i] = 0;
      end
      m_state = 0;
      m_esc   = 0;
      m_ts    = '0;
    end
    for (int i = 0; i < NSRC; i++) begin
      m_min[i] += int'(mn[i]);
      m_maj[i] += int'(mj[i]);
      m_scr[i] += int'(sc[i]);
    end
    if (m_state != 2) begin
      if (mj != 0) begin
        m_state = 2; m_irq = 1'b1; m_ts = m_cyc;
      end else if (mn != 0) begin
        if (m_state == 0) begin
          m_state = 1; m_esc = 0;
        end else begin
          m_esc++;
          if (m_esc >= ESC) begin
            m_state = 2; m_irq = 1'b1; m_ts = m_cyc;
          end
        end
      end
    end
    m_cyc = m_cyc + 32'd1;
  endtask

  task automatic step(input logic [3:0] mn, mj, sc, input logic cl, rq,
                      input logic [1:0] kd, input logic [3:0] sr);
    logic [31:0] e_big, e_sat;
    min_err_i = mn; maj_err_i = mj; scrub_i = sc; clr_i = cl;
    rd_req_i = rq; rd_kind_i = kd; rd_src_i = sr;
    e_big = rq ? exp_read(int'(kd), int'(sr), MAXD) : 32'd0;
    e_sat = rq ? exp_read(int'(kd), int'(sr), MAXS) : 32'd0;
    model_update(mn, mj, sc, cl);
    @(posedge clk_i);
    #1;
    check("rd_valid", 32'(rd_valid), 32'(rq));
    check("rd_data", rd_data, e_big);
    check("rd_data_cw4", s_rd_data, e_sat);
    check("degraded", 32'(degraded), 32'(m_state == 1));
    check("alarm", 32'(alarm), 32'(m_state == 2));
    check("irq", 32'(irq), 32'(m_irq));
    check("alarm_cw4", 32'(s_alarm), 32'(m_state == 2));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_data"}, rd_data, 32'd0);
    check({tag, "_degraded"}, 32'(degraded), 32'd0);
    check({tag, "_alarm"}, 32'(alarm), 32'd0);
    check({tag, "_irq"}, 32'(irq), 32'd0);
    check({tag, "_valid_cw4"}, 32'(s_rd_valid), 32'd0);
  endtask

  initial begin
    logic [3:0] mn, mj, sc;
    logic [1:0] kd;
    logic [3:0] sr;

    rst_i = 1'b1; min_err_i = '0; maj_err_i = '0; scrub_i = '0; clr_i = 1'b0;
    rd_req_i = 1'b1; rd_kind_i = 2'd0; rd_src_i = 4'd0;
    repeat (3) @(posedge clk_i);
    #1;
    check_quiet("reset");
    @(negedge clk_i);
    rst_i = 1'b0; rd_req_i = 1'b0;
    model_reset();

    // Minor errors on source 0 for three cycles
    for (int i = 0; i < 3; i++) step(4'b0001, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 4'd0);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 4'd0);
    check("min3_data", rd_data, 32'd3);
    check("min3_degraded", 32'(degraded), 32'd1);
    check("min3_alarm", 32'(alarm), 32'd0);

    // Escalation: eight minor-error cycles while DEGRADED
    step(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 4'd0);
    step(4'b0001, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 4'd0);
    for (int i = 0; i < 7; i++) step(4'b0100, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 4'd0);
    check("esc7_alarm", 32'(alarm), 32'd0);
    step(4'b0100, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 4'd0);
    check("esc8_alarm", 32'(alarm), 32'd1);
    check("esc8_irq", 32'(irq), 32'd1);
    step(4'b0100, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 4'd0);
    check("esc_status", rd_data, 32'd2);
    check("esc_irq_once", 32'(irq), 32'd0);

    // Saturation: 20 scrub cycles on source 1
    step(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 4'd0);
    for (int i = 0; i < 20; i++) step(4'h0, 4'h0, 4'b0010, 1'b0, 1'b0, 2'd0, 4'd0);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 2'd2, 4'd1);
    check("sat_cw4", s_rd_data, 32'd15);
    check("sat_cw16", rd_data, 32'd20);

    // Clear coinciding with a major error
    step(4'h0, 4'b0001, 4'h0, 1'b0, 1'b0, 2'd0, 4'd0);
    step(4'h0, 4'b1000, 4'h0, 1'b1, 1'b0, 2'd0, 4'd0);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 4'd3);
    check("clrmaj_cnt", rd_data, 32'd1);
    check("clrmaj_alarm", 32'(alarm), 32'd1);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 4'd0);
    check("clrmaj_other", rd_data, 32'd0);

    // Read racing an increment returns the pre-update value
    step(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 4'd0);
    step(4'h0, 4'b0001, 4'h0, 1'b0, 1'b1, 2'd1, 4'd0);
    check("race_pre", rd_data, 32'd0);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 4'd0);
    check("race_post", rd_data, 32'd1);

    // Out-of-range source and unused status sub-select
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 4'd9);
    check("oor_valid", 32'(rd_valid), 32'd1);
    check("oor_data", rd_data, 32'd0);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 4'd5);
    check("status_sub5", rd_data, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      mn = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      mj = ($urandom_range(0, 29) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      sc = 4'($urandom_range(0, 15));
      kd = 2'($urandom_range(0, 3));
      sr = (kd == 2'd3) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 5));
      step(mn, mj, sc, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), kd, sr);
    end

    // Asynchronous reset mid-cycle with a read pending
    rd_req_i = 1'b1;
    #3 rst_i = 1'b1;
    #1;
    check_quiet("async_rst");
    repeat (2) @(posedge clk_i);
    #1;
    check_quiet("held_rst");
    @(negedge clk_i);
    rst_i = 1'b0; rd_req_i = 1'b0;
    model_reset();

    // Timestamp: major error in cycle 100 after reset
    idle(100);
    step(4'h0, 4'b0001, 4'h0, 1'b0, 1'b0, 2'd0, 4'd0);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 4'd1);
`ifdef FATORI_ERR_TIMESTAMP_EN
    check("timestamp", rd_data, 32'd100);
`else
    check("timestamp", rd_data, 32'd0);
`endif
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 4'd0);
    check("post_rst_maj", rd_data, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fatori_err_collector.md
FATORI_ERR_COLLECTOR -- requirements
Module: fatori_err_collector

Interface
REQ-001 SHALL have parameter NSRC, default 4: number of monitored wrappers, 1..16.
REQ-002 SHALL have parameter CW, default 16: width of each event counter, 4..32.
REQ-003 SHALL have parameter ESC_THRESH, default 8: minor-error cycles in DEGRADED that escalate to ALARM, 1..2^CW-1.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port min_err_i, input, NSRC: per-wrapper voted minority-disagreement flags.
REQ-007 SHALL have port maj_err_i, input, NSRC: per-wrapper no-majority flags.
REQ-008 SHALL have port scrub_i, input, NSRC: per-wrapper scrub-occurred flags.
REQ-009 SHALL have port clr_i, input, 1: synchronous clear of counters and state.
REQ-010 SHALL have port rd_req_i, input, 1: read request.
REQ-011 SHALL have port rd_kind_i, input, 2: read kind; 0 min, 1 maj, 2 scrub, 3 status/timestamp.
REQ-012 SHALL have port rd_src_i, input, 4: source index, or the status sub-select when rd_kind_i is 3.
REQ-013 SHALL have port rd_valid_o, output, 1: read data valid.
REQ-014 SHALL have port rd_data_o, output, 32: read data, zero-extended.
REQ-015 SHALL have port degraded_o, output, 1: state is DEGRADED.
REQ-016 SHALL have port alarm_o, output, 1: state is ALARM.
REQ-017 SHALL have port irq_o, output, 1: one-cycle pulse on entry to ALARM.

Function
REQ-018 SHALL hold 3*NSRC counters (min/maj/scrub per source), each incremented by 1 in every cycle its flag is high, and saturating at 2^CW-1 with no wrap.
REQ-019 SHALL implement FSM states OK, DEGRADED and ALARM.
REQ-020 SHALL transition OK->DEGRADED in the cycle after any min_err_i bit is high, provided no maj_err_i bit is high.
REQ-021 SHALL transition OK or DEGRADED->ALARM in the cycle after any maj_err_i bit is high; maj takes priority over min in the same cycle.
REQ-022 SHALL count esc_cnt cycles in DEGRADED with any min_err_i bit high (the OR of all bits, i.e. +1 per cycle, not a popcount).
REQ-023 SHALL transition DEGRADED->ALARM when esc_cnt reaches ESC_THRESH; esc_cnt SHALL zero on DEGRADED entry.
REQ-024 SHALL keep ALARM sticky; only clr_i or reset exits it.
REQ-025 SHALL, on clr_i, zero all counters and esc_cnt and set the state to OK; flags high in the same cycle SHALL then apply to the cleared state (counter=1, FSM evaluated from OK), so no event is lost.
REQ-026 SHALL raise irq_o exactly once per ALARM entry, in the same cycle alarm_o first goes high.
REQ-027 SHALL register reads: rd_req_i in cycle t gives rd_valid_o=1 and rd_data_o in cycle t+1; back-to-back reads SHALL be supported one per cycle.
REQ-028 SHALL return the pre-update (cycle t) counter value when a read hits a counter incremented in cycle t.
REQ-029 SHALL return 0 with rd_valid_o=1 for rd_src_i >= NSRC when rd_kind_i is 0-2.
REQ-030 SHALL return {30'b0, state} for rd_kind_i=3 with rd_src_i=0, encoded OK=0, DEGRADED=1, ALARM=2.
REQ-031 SHALL hold rd_data_o at 0 while rd_valid_o is 0.

Reset
REQ-032 SHALL, on rst_i assertion (asynchronously, mid-operation included), zero all counters, esc_cnt and the timestamp and set the state to OK.
REQ-033 SHALL hold rd_valid_o, rd_data_o, degraded_o, alarm_o and irq_o at 0 during reset; a pending read SHALL be discarded.

Configuration
REQ-034 SHALL use macro FATORI_ERR_TIMESTAMP_EN to compile the timestamp feature in or out.
REQ-035 SHALL, with the macro defined, run a free-running 32-bit wrapping cycle counter from reset and latch its value in the cycle ALARM is entered; the latch is cleared by clr_i/reset and read at rd_kind_i=3, rd_src_i=1.
REQ-036 SHALL, without the macro, contain no cycle counter or latch and return 0 for rd_kind_i=3, rd_src_i=1.

Verification
REQ-037 SHALL cover: min_err_i=4'b0001 for 3 cycles, then read kind 0 src 0 -> rd_data_o=3, degraded_o=1, alarm_o=0.
REQ-038 SHALL cover: ESC_THRESH=8, min_err_i[2] high 8 cycles -> alarm_o=1 with a single irq_o pulse; read status -> 2.
REQ-039 SHALL cover: CW=4, scrub_i[1] high 20 cycles -> scrub count reads 15.
REQ-040 SHALL cover: clr_i and maj_err_i[3] in the same cycle -> maj count src 3 reads 1, alarm_o=1.
REQ-041 SHALL cover: read kind 1 src 0 in the same cycle maj_err_i[0] rises from count 0 -> returns 0, a subsequent read returns 1.
REQ-042 SHALL cover: with FATORI_ERR_TIMESTAMP_EN, maj_err_i[0] at cycle 100 after reset -> timestamp read returns 100; without the macro it returns 0.
